eq_band_mixer: RTL

- Synthesis-side counterpart to the equalizer's FIR band filters.
- Accepts one 16-bit signed output sample from each of the three band filters (low, mid, high) as a single handshaked beat.
- Applies a programmable per-band gain using one time-shared multiplier, sums the three products, and rounds and saturates the sum back to the 8-bit signed sample width.
- Presents the result on a valid/ready output toward the DAC/output stage.

---
 rtl/eq_band_mixer_pkg.sv | 24 ++
 rtl/eq_band_mixer_if.sv | 27 ++
 rtl/eq_band_mixer_round_sat.sv | 45 ++++
 rtl/eq_band_mixer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/eq_band_mixer_pkg.sv
// Shared widths, scaling constants and FSM encoding for the equalizer band mixer.
// Used by eq_round_sat, the bus interface and the eq_band_mixer top.
package eq_pkg;

    localparam int WORD_IN  = 16;
    localparam int WORD_OUT = 8;
    localparam int GAIN_W   = 8;
    localparam int NBANDS   = 3;
    localparam int PROD_W   = 25;
    localparam int ACC_W    = 27;
    localparam int SCALE_SH = 12;

    localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC0 = 3'd1,
        ST_MAC1 = 3'd2,
        ST_MAC2 = 3'd3,
        ST_SAT  = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

endpackage

// File: rtl/eq_band_mixer_if.sv
// Band-sample input, gain-write and mixed-output bus of eq_band_mixer.
// The master side drives samples and gain writes; the mixer is the slave.
interface eq_band_mixer_if;
    import eq_pkg::*;

    logic [NBANDS*WORD_IN-1:0]  band_in;
    logic                       in_valid;
    logic                       in_ready;
    logic                       gain_wr;
    logic [1:0]                 gain_addr;
    logic [GAIN_W-1:0]          gain_data;
    logic signed [WORD_OUT-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       sat_flag;

    modport master (
        output band_in, in_valid, gain_wr, gain_addr, gain_data, out_ready,
        input  in_ready, out_data, out_valid, sat_flag
    );

    modport slave (
        input  band_in, in_valid, gain_wr, gain_addr, gain_data, out_ready,
        output in_ready, out_data, out_valid, sat_flag
    );

endinterface

// File: rtl/eq_band_mixer_round_sat.sv
// Combinational scale, round and clamp of the 27-bit accumulator to an 8-bit sample.
// EQ_BAND_MIXER_ROUND_EN selects round-half-up; otherwise the shift truncates toward -inf.
module eq_round_sat
    import eq_pkg::*;
(
    input  logic signed [ACC_W-1:0]    acc,
    output logic signed [WORD_OUT-1:0] data,
    output logic                       sat
);

    localparam int SUM_W = ACC_W + 1;

`ifdef EQ_BAND_MIXER_ROUND_EN
    localparam logic signed [SUM_W-1:0] RND = 28'sd2048;
`else
    localparam logic signed [SUM_W-1:0] RND = 28'sd0;
`endif

    localparam logic signed [SUM_W-1:0] RES_MAX = 28'sd127;
    localparam logic signed [SUM_W-1:0] RES_MIN = -28'sd128;

    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] shifted_s;

    // One extra bit keeps the rounding add free of overflow.
    assign sum_s     = $signed({acc[ACC_W-1], acc}) + RND;
    assign shifted_s = sum_s >>> SCALE_SH;

    // Clamp to the signed output range and flag any clipping.
    always_comb begin
        data = 8'sd0;
        sat  = 1'b0;
        if (shifted_s > RES_MAX) begin
            data = 8'sh7f;
            sat  = 1'b1;
        end else if (shifted_s < RES_MIN) begin
            data = -8'sd128;
            sat  = 1'b1;
        end else begin
            data = shifted_s[WORD_OUT-1:0];
            sat  = 1'b0;
        end
    end

endmodule

// File: rtl/eq_band_mixer.sv
// Three-band gain mixer: one shared multiplier walks the bands, then scale/round/saturate.
// Rounding mode is selected by EQ_BAND_MIXER_ROUND_EN (see eq_round_sat).
module eq_band_mixer
    import eq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    eq_band_mixer_if.slave bus
);

    state_t                     state_r;
    state_t                     next_state_s;
    logic signed [WORD_IN-1:0]  band_r      [NBANDS];
    logic [GAIN_W-1:0]          gain_r      [NBANDS];
    logic [GAIN_W-1:0]          gain_snap_r [NBANDS];
    logic signed [ACC_W-1:0]    acc_r;
    logic signed [WORD_IN-1:0]  mul_a_s;
    logic [GAIN_W-1:0]          mul_g_s;
    logic signed [PROD_W-1:0]   prod_s;
    logic signed [WORD_OUT-1:0] out_data_r;
    logic signed [WORD_OUT-1:0] rs_data_s;
    logic                       sat_r;
    logic                       rs_sat_s;
    logic                       out_valid_r;
    logic                       in_ready_r;
    logic                       accept_s;

    // in_ready_r is low on the cycle right after reset, so it (not the state) gates acceptance.
    assign accept_s = in_ready_r & bus.in_valid;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_MAC0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MAC0: next_state_s = ST_MAC1;
            ST_MAC1: next_state_s = ST_MAC2;
            ST_MAC2: next_state_s = ST_SAT;
            ST_SAT:  next_state_s = ST_OUT;
            ST_OUT: begin
                if (bus.out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_OUT;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Gain registers, writable in any state; address 3 is ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NBANDS; i++) gain_r[i] <= GAIN_UNITY;
        end else if (bus.gain_wr) begin
            case (bus.gain_addr)
                2'd0:    gain_r[0] <= bus.gain_data;
                2'd1:    gain_r[1] <= bus.gain_data;
                2'd2:    gain_r[2] <= bus.gain_data;
                default: ;
            endcase
        end
    end

    // Shared multiplier operand select.
    always_comb begin
        mul_a_s = '0;
        mul_g_s = '0;
        case (state_r)
            ST_MAC0: begin mul_a_s = band_r[0]; mul_g_s = gain_snap_r[0]; end
            ST_MAC1: begin mul_a_s = band_r[1]; mul_g_s = gain_snap_r[1]; end
            ST_MAC2: begin mul_a_s = band_r[2]; mul_g_s = gain_snap_r[2]; end
            default: begin mul_a_s = '0;        mul_g_s = '0;             end
        endcase
    end

    assign prod_s = PROD_W'(mul_a_s) * $signed(PROD_W'({1'b0, mul_g_s}));

    eq_round_sat u_round_sat (
        .acc  (acc_r),
        .data (rs_data_s),
        .sat  (rs_sat_s)
    );

    // Capture, accumulate, result and handshake registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_r       <= '0;
            out_data_r  <= '0;
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            for (int i = 0; i < NBANDS; i++) begin
                band_r[i]      <= '0;
                gain_snap_r[i] <= GAIN_UNITY;
            end
        end else begin
            in_ready_r  <= (next_state_s == ST_IDLE);
            out_valid_r <= (next_state_s == ST_OUT);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_r <= '0;
                        for (int i = 0; i < NBANDS; i++) begin
                            band_r[i]      <= $signed(bus.band_in[i*WORD_IN +: WORD_IN]);
                            gain_snap_r[i] <= gain_r[i];
                        end
                    end
                end
                ST_MAC0, ST_MAC1, ST_MAC2: acc_r <= acc_r + ACC_W'(prod_s);
                ST_SAT: begin
                    out_data_r <= rs_data_s;
                    sat_r      <= rs_sat_s;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.sat_flag  = sat_r;

endmodule
